// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-granular sharing of one UART transmitter
// among NREQ byte-stream requesters. A granted requester keeps the UART until
// its byte flagged last has been started, or until it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [NREQ-1:0]     reqValid,
    input  logic [8*NREQ-1:0]   reqData,
    input  logic [NREQ-1:0]     reqLast,
    output logic [NREQ-1:0]     reqReady,
    input  logic                txBusy,
    output logic                txStart,
    output logic [7:0]          txData,
    output logic                grantValid,
    output logic [IDW-1:0]      grantId,
    output logic                abortPulse,
    output logic [15:0]         bytesSent
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        GUARD
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_valid;
    logic [15:0]      tout_cnt;
    logic             last_flag;
    logic [7:0]       tx_data;
    logic [15:0]      byte_count;
    logic             abort_q;

    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_id;
    logic             scan_hit;
    logic [IDW-1:0]   next_ptr;
    logic [7:0]       granted_byte;
    logic             granted_valid;
    logic             granted_last;

    logic             grant;
    logic             accept;
    logic             abort_now;
    logic             release_grant;
    logic             tout_inc;

    assign granted_byte  = reqData[{grant_id, 3'b000} +: 8];
    assign granted_valid = reqValid[grant_id];
    assign granted_last  = reqLast[grant_id];
    assign next_ptr      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    // Scan requesters starting at the round-robin pointer; first valid index wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = '0;
        scan_sum = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            if (!scan_hit && reqValid[scan_sum[IDW-1:0]]) begin
                scan_hit = 1'b1;
                scan_id  = scan_sum[IDW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the combinational handshake outputs and datapath strobes.
    always_comb begin
        state_next    = state;
        txStart       = 1'b0;
        reqReady      = '0;
        grant         = 1'b0;
        accept        = 1'b0;
        abort_now     = 1'b0;
        release_grant = 1'b0;
        tout_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    grant      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Only cycles with the UART free count towards the stall timeout.
                if (!txBusy) begin
                    reqReady = NREQ'(1) << grant_id;
                    if (granted_valid) begin
                        accept     = 1'b1;
                        state_next = START;
                    end else if (tout_cnt == 16'(TIMEOUT - 1)) begin
                        abort_now  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tout_inc = 1'b1;
                    end
                end
            end
            START: begin
                txStart    = 1'b1;
                state_next = GUARD;
            end
            GUARD: begin
                if (last_flag) begin
                    release_grant = 1'b1;
                    state_next    = IDLE;
                end else begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant ownership, byte latch, stall counter, pointer rotation and byte counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            tout_cnt    <= '0;
            last_flag   <= 1'b0;
            tx_data     <= '0;
            byte_count  <= '0;
            abort_q     <= 1'b0;
        end else begin
            abort_q <= abort_now;
            if (grant) begin
                grant_id    <= scan_id;
                grant_valid <= 1'b1;
                tout_cnt    <= '0;
            end
            if (accept) begin
                tx_data   <= granted_byte;
                last_flag <= granted_last;
                tout_cnt  <= '0;
            end
            if (tout_inc) begin
                tout_cnt <= tout_cnt + 16'd1;
            end
            if (abort_now || release_grant) begin
                grant_valid <= 1'b0;
                rr_ptr      <= next_ptr;
                tout_cnt    <= '0;
            end
            if (state == START) begin
                byte_count <= byte_count + 16'd1;
            end
        end
    end

    assign txData     = tx_data;
    assign grantValid = grant_valid;
    assign grantId    = grant_id;
    assign abortPulse = abort_q;
    assign bytesSent  = byte_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester byte queues feed the DUT,
// a UART model raises txBusy after each start, and a scoreboard of expected
// (owner, byte) pairs is compared against every txStart.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TOUT = 8;
    localparam int BUSY = 10;

    logic                clk = 1'b0;
    logic                rstN = 1'b0;
    logic [NREQ-1:0]     reqValid = '0;
    logic [8*NREQ-1:0]   reqData = '0;
    logic [NREQ-1:0]     reqLast = '0;
    logic [NREQ-1:0]     reqReady;
    logic                txBusy;
    logic                txStart;
    logic [7:0]          txData;
    logic                grantValid;
    logic [IDW-1:0]      grantId;
    logic                abortPulse;
    logic [15:0]         bytesSent;

    int checks   = 0;
    int failures = 0;

    logic [8:0]       rq [NREQ][$];
    logic [IDW+7:0]   sb [$];
    logic [NREQ-1:0]  acc = '0;
    int               busy_cnt = 0;
    int               n_starts = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TOUT)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqLast    (reqLast),
        .reqReady   (reqReady),
        .txBusy     (txBusy),
        .txStart    (txStart),
        .txData     (txData),
        .grantValid (grantValid),
        .grantId    (grantId),
        .abortPulse (abortPulse),
        .bytesSent  (bytesSent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic push_exp(input int r, input logic [7:0] d);
        sb.push_back({IDW'(r), d});
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && queues_empty() && !grantValid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        sb.delete();
        @(negedge clk); #1;
        rstN = 1'b1;
    endtask

    // UART model: busy for BUSY cycles starting the cycle after txStart.
    always @(posedge clk) begin
        if (txStart) busy_cnt <= BUSY;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign txBusy = (busy_cnt != 0);

    // Requester engine: retire accepted bytes, present queue heads.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                reqValid[i]       = 1'b1;
                reqData[8*i +: 8] = rq[i][0][7:0];
                reqLast[i]        = rq[i][0][8];
            end else begin
                reqValid[i]       = 1'b0;
                reqData[8*i +: 8] = '0;
                reqLast[i]        = 1'b0;
            end
        end
        acc = rstN ? (reqValid & reqReady) : '0;
    end

    // Monitor: handshake legality every cycle, scoreboard compare on every start.
    always @(negedge clk) begin
        if (rstN) begin
            chk("ready_while_busy", 32'(reqReady & {NREQ{txBusy}}), 32'd0);
            chk("ready_not_owner",
                32'(reqReady & ~(grantValid ? (NREQ'(1) << grantId) : NREQ'(0))), 32'd0);
            if (txStart) begin
                n_starts++;
                if (sb.size() == 0) begin
                    chk("start_expected", 32'(sb.size() != 0), 32'd1);
                end else begin
                    logic [IDW+7:0] e;
                    e = sb.pop_front();
                    chk("txData", 32'(txData), 32'(e[7:0]));
                    chk("grantId", 32'(grantId), 32'(e[IDW+7:8]));
                    chk("grantValid_at_start", 32'(grantValid), 32'd1);
                end
            end
        end
    end

    initial begin
        int n;
        int wc;
        int starts0;
        logic [15:0] sent0;
        bit hit;

        // Reset values
        @(negedge clk); #1;
        chk("rst_txStart", 32'(txStart), 32'd0);
        chk("rst_txData", 32'(txData), 32'd0);
        chk("rst_grantValid", 32'(grantValid), 32'd0);
        chk("rst_grantId", 32'(grantId), 32'd0);
        chk("rst_abortPulse", 32'(abortPulse), 32'd0);
        chk("rst_bytesSent", 32'(bytesSent), 32'd0);
        chk("rst_reqReady", 32'(reqReady), 32'd0);
        rstN = 1'b1;

        // Single requester, 3-byte frame, latency and release timing
        push_req(0, 8'h11, 1'b0); push_req(0, 8'h22, 1'b0); push_req(0, 8'h33, 1'b1);
        push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33);
        n = 0;
        while (!reqValid[0] && n < 20) begin @(negedge clk); #1; n++; end
        n = 0;
        while (!txStart && n < 20) begin @(negedge clk); #1; n++; end
        chk("first_latency", 32'(n), 32'd2);
        n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); #1; n++; end
        chk("t1_all_started", 32'(sb.size()), 32'd0);
        @(negedge clk); #1;
        chk("t1_guard_grantValid", 32'(grantValid), 32'd1);
        @(negedge clk); #1;
        chk("t1_idle_grantValid", 32'(grantValid), 32'd0);
        chk("t1_bytesSent", 32'(bytesSent), 32'd3);

        // Two simultaneous requesters, two frames each, from reset
        do_reset();
        push_req(1, 8'hB1, 1'b0); push_req(1, 8'hB2, 1'b1);
        push_req(1, 8'hB5, 1'b0); push_req(1, 8'hB6, 1'b1);
        push_req(2, 8'hC1, 1'b0); push_req(2, 8'hC2, 1'b1);
        push_req(2, 8'hC5, 1'b0); push_req(2, 8'hC6, 1'b1);
        push_exp(1, 8'hB1); push_exp(1, 8'hB2); push_exp(2, 8'hC1); push_exp(2, 8'hC2);
        push_exp(1, 8'hB5); push_exp(1, 8'hB6); push_exp(2, 8'hC5); push_exp(2, 8'hC6);
        wait_done("t2_done");
        chk("t2_bytesSent", 32'(bytesSent), 32'd8);

        // Continuous req0, late one-shot req3 gets the next turn
        push_req(0, 8'hD1, 1'b0); push_req(0, 8'hD2, 1'b1);
        push_req(0, 8'hD3, 1'b0); push_req(0, 8'hD4, 1'b1);
        push_req(0, 8'hD5, 1'b0); push_req(0, 8'hD6, 1'b1);
        push_exp(0, 8'hD1); push_exp(0, 8'hD2); push_exp(3, 8'hE1);
        push_exp(0, 8'hD3); push_exp(0, 8'hD4); push_exp(0, 8'hD5); push_exp(0, 8'hD6);
        n = 0;
        while (!grantValid && n < 20) begin @(negedge clk); #1; n++; end
        chk("t3_grant0", 32'(grantId), 32'd0);
        push_req(3, 8'hE1, 1'b1);
        wait_done("t3_done");

        // Stall timeout: req2 sends one byte then goes quiet
        sent0   = bytesSent;
        starts0 = n_starts;
        push_req(2, 8'h5A, 1'b0);
        push_exp(2, 8'h5A);
        wc  = 0;
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (abortPulse) begin hit = 1'b1; break; end
            if (reqReady[2] && !reqValid[2]) wc++;
        end
        chk("t4_abort_seen", 32'(hit), 32'd1);
        chk("t4_wait_cycles", 32'(wc), 32'd8);
        chk("t4_grantValid", 32'(grantValid), 32'd0);
        @(negedge clk); #1;
        chk("t4_abort_one_cycle", 32'(abortPulse), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_starts", 32'(n_starts - starts0), 32'd1);
        chk("t4_bytesSent", 32'(bytesSent), 32'(sent0 + 16'd1));
        chk("t4_idle", 32'(grantValid), 32'd0);

        // Asynchronous reset during START of byte 2
        push_req(0, 8'hA1, 1'b0); push_req(0, 8'hA2, 1'b0);
        push_req(0, 8'hA3, 1'b0); push_req(0, 8'hA4, 1'b1);
        push_exp(0, 8'hA1); push_exp(0, 8'hA2);
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (txStart && txData == 8'hA2) begin hit = 1'b1; break; end
        end
        chk("t5_reached_byte2", 32'(hit), 32'd1);
        rstN = 1'b0;
        #1;
        chk("t5_rst_txStart", 32'(txStart), 32'd0);
        chk("t5_rst_txData", 32'(txData), 32'd0);
        chk("t5_rst_grantValid", 32'(grantValid), 32'd0);
        chk("t5_rst_abortPulse", 32'(abortPulse), 32'd0);
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        sb.delete();
        @(negedge clk); @(negedge clk); #1;
        rstN = 1'b1;
        starts0 = n_starts;
        push_req(0, 8'hA5, 1'b1);
        push_exp(0, 8'hA5);
        wait_done("t5_done");
        chk("t5_starts", 32'(n_starts - starts0), 32'd1);
        chk("t5_bytesSent", 32'(bytesSent), 32'd1);

        // Byte counter wrap
        force dut.byte_count = 16'hFFFE;
        @(negedge clk); #1;
        release dut.byte_count;
        push_req(1, 8'h01, 1'b1);
        push_exp(1, 8'h01);
        wait_done("t6a_done");
        chk("t6_bytesSent_ffff", 32'(bytesSent), 32'h0000FFFF);
        push_req(1, 8'h02, 1'b1);
        push_exp(1, 8'h02);
        wait_done("t6b_done");
        chk("t6_bytesSent_wrap", 32'(bytesSent), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
